// File: rtl/signal_field_parser_pkg.sv
// Shared constants and types for the SIGNAL word parser: field positions, defaults, error codes, FSM states.
// No logic; imported by the interface, the collector and the top level.
package signal_field_parser_pkg;

    localparam logic [7:0]  SIG_HDR_DEF = 8'hB1;
    localparam logic [15:0] MAX_LEN_DEF = 16'd4095;

    localparam int WORD_W   = 32;
    localparam int TYPE_W   = 4;
    localparam int LEN_W    = 16;
    localparam int HDR_LSB  = 0;
    localparam int TYPE_LSB = 8;
    localparam int LEN_LSB  = 12;
    localparam int PAR_BIT  = 28;
    localparam int TAIL_LSB = 29;

    typedef enum logic [1:0] {
        ERR_HDR  = 2'd0,
        ERR_PAR  = 2'd1,
        ERR_TAIL = 2'd2,
        ERR_LEN  = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHECK   = 2'd2
    } state_e;

    function automatic logic [TYPE_W-1:0] word_type(input logic [WORD_W-1:0] w);
        return w[TYPE_LSB +: TYPE_W];
    endfunction

    function automatic logic [LEN_W-1:0] word_len(input logic [WORD_W-1:0] w);
        return w[LEN_LSB +: LEN_W];
    endfunction

endpackage

// File: rtl/signal_field_parser_if.sv
// Serial SIGNAL input and decoded result bundle; master drives the serial side, slave is the parser.
// No flow control: serial bits are qualified by ssg_di_vld, results are single-cycle pulses.
interface signal_field_parser_if;
    import signal_field_parser_pkg::*;

    logic              new_frame;
    logic              ssg_di;
    logic              ssg_di_vld;
    logic [TYPE_W-1:0] sig_type;
    logic [LEN_W-1:0]  sig_len;
    logic              sig_vld;
    logic              sig_err;
    logic [1:0]        sig_err_code;
    logic              busy;

    modport master (
        output new_frame, ssg_di, ssg_di_vld,
        input  sig_type, sig_len, sig_vld, sig_err, sig_err_code, busy
    );

    modport slave (
        input  new_frame, ssg_di, ssg_di_vld,
        output sig_type, sig_len, sig_vld, sig_err, sig_err_code, busy
    );

endinterface

// File: rtl/signal_field_parser_sig_shift_collector.sv
// Assembles the 32-bit SIGNAL word LSB first, counts accepted bits and keeps a running XOR of bits 0..28.
// peek_o shows the word including the bit being shifted this cycle, so checks can run on the 32nd bit.
module sig_shift_collector
    import signal_field_parser_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              shift_i,
    input  logic              di_i,
    output logic [WORD_W-1:0] peek_o,
    output logic [4:0]        cnt_o,
    output logic              par_o
);

    logic [WORD_W-1:0] word_q;
    logic [4:0]        cnt_q;
    logic              par_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
            par_q  <= 1'b0;
        end else if (start_i) begin
            // A new frame may carry its bit 0 in the same cycle.
            word_q <= {{(WORD_W-1){1'b0}}, shift_i & di_i};
            cnt_q  <= {4'd0, shift_i};
            par_q  <= shift_i & di_i;
        end else if (shift_i) begin
            word_q[cnt_q] <= di_i;
            cnt_q         <= cnt_q + 5'd1;
            if (cnt_q <= 5'(PAR_BIT))
                par_q <= par_q ^ di_i;
        end
    end

    always_comb begin
        peek_o = word_q;
        if (shift_i && !start_i)
            peek_o[cnt_q] = di_i;
    end

    assign cnt_o = cnt_q;
    assign par_o = par_q;

endmodule

// File: rtl/signal_field_parser.sv
// Collects a serial 32-bit SIGNAL word and checks it; sig_vld/sig_err pulse one cycle after the 32nd bit.
// new_frame aborts any word in flight; input gaps of any length are tolerated, no backpressure.
module signal_field_parser
    import signal_field_parser_pkg::*;
#(
    parameter logic [7:0]  SIG_HDR = SIG_HDR_DEF,
    parameter logic [15:0] MAX_LEN = MAX_LEN_DEF
) (
    input  logic                 ssg_clk,
    input  logic                 ssg_rst,
    signal_field_parser_if.slave bus
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] full_word;
    logic [4:0]        cnt;
    logic              par;
    logic              shift_en;
    logic              last_bit;
    logic              chk_err;
    err_code_e         chk_code;

    logic              sig_vld_q, sig_err_q, busy_q;
    logic [1:0]        sig_err_code_q;
    logic [TYPE_W-1:0] sig_type_q;
    logic [LEN_W-1:0]  sig_len_q;

    assign shift_en = bus.ssg_di_vld && (bus.new_frame || state_q == ST_COLLECT);
    assign last_bit = (state_q == ST_COLLECT) && !bus.new_frame && bus.ssg_di_vld && (cnt == 5'd31);

    sig_shift_collector u_collector (
        .clk     (ssg_clk),
        .rst     (ssg_rst),
        .start_i (bus.new_frame),
        .shift_i (shift_en),
        .di_i    (bus.ssg_di),
        .peek_o  (full_word),
        .cnt_o   (cnt),
        .par_o   (par)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (bus.new_frame) state_d = ST_COLLECT;
            ST_COLLECT: if (bus.new_frame) state_d = ST_COLLECT;
                        else if (last_bit) state_d = ST_CHECK;
            ST_CHECK:   state_d = bus.new_frame ? ST_COLLECT : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Checks in priority order; the first failing one names the error.
    always_comb begin
        chk_err  = 1'b1;
        chk_code = ERR_HDR;
        if (full_word[HDR_LSB +: 8] != SIG_HDR)
            chk_code = ERR_HDR;
        else if (par)
            chk_code = ERR_PAR;
        else if (full_word[WORD_W-1:TAIL_LSB] != 3'd0)
            chk_code = ERR_TAIL;
        else if (word_len(full_word) == '0 || word_len(full_word) > MAX_LEN)
            chk_code = ERR_LEN;
        else
            chk_err = 1'b0;
    end

    // Results are registered on the 32nd bit so they are visible during the CHECK cycle.
    always_ff @(posedge ssg_clk or posedge ssg_rst) begin
        if (ssg_rst) begin
            state_q        <= ST_IDLE;
            busy_q         <= 1'b0;
            sig_vld_q      <= 1'b0;
            sig_err_q      <= 1'b0;
            sig_err_code_q <= '0;
            sig_type_q     <= '0;
            sig_len_q      <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= (state_d != ST_IDLE);
            sig_vld_q <= 1'b0;
            sig_err_q <= 1'b0;
            if (last_bit) begin
                if (chk_err) begin
                    sig_err_q      <= 1'b1;
                    sig_err_code_q <= chk_code;
                end else begin
                    sig_vld_q  <= 1'b1;
                    sig_type_q <= word_type(full_word);
                    sig_len_q  <= word_len(full_word);
                end
            end
        end
    end

    assign bus.sig_vld      = sig_vld_q;
    assign bus.sig_err      = sig_err_q;
    assign bus.sig_err_code = sig_err_code_q;
    assign bus.sig_type     = sig_type_q;
    assign bus.sig_len      = sig_len_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_signal_field_parser.sv
// Bench for signal_field_parser: expected pulses are queued when a word's last bit is driven
// and matched (value and cycle) when sig_vld/sig_err appears.
module tb_signal_field_parser;
    import signal_field_parser_pkg::*;

    logic ssg_clk = 1'b0;
    logic ssg_rst;
    always #5 ssg_clk = ~ssg_clk;

    signal_field_parser_if sif();

    signal_field_parser #(.SIG_HDR(8'hB1), .MAX_LEN(16'd4095)) dut (
        .ssg_clk (ssg_clk),
        .ssg_rst (ssg_rst),
        .bus     (sif)
    );

    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        logic [3:0]  typ;
        logic [15:0] len;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [3:0]  m_type = '0;
    logic [15:0] m_len  = '0;
    logic [1:0]  m_code = '0;

    function automatic logic [31:0] mk_word(input logic [7:0] hdr, input logic [3:0] t,
                                            input logic [15:0] l, input logic [2:0] tail,
                                            input bit bad_par);
        logic [31:0] w;
        w        = '0;
        w[7:0]   = hdr;
        w[11:8]  = t;
        w[27:12] = l;
        w[28]    = (^w[27:0]) ^ bad_par;
        w[31:29] = tail;
        return w;
    endfunction

    task automatic push_expect(input logic [31:0] w);
        exp_t        e;
        logic [15:0] l;
        l        = w[27:12];
        e.is_err = 1'b1;
        if (w[7:0] != 8'hB1)             m_code = 2'd0;
        else if (^w[28:0])               m_code = 2'd1;
        else if (w[31:29] != 3'd0)       m_code = 2'd2;
        else if (l == 0 || l > 16'd4095) m_code = 2'd3;
        else begin
            e.is_err = 1'b0;
            m_type   = w[11:8];
            m_len    = l;
        end
        e.code = m_code;
        e.typ  = m_type;
        e.len  = m_len;
        e.cyc  = cyc + 1;
        sb.push_back(e);
    endtask

    // One clock: drive at the current point, sample at the following falling edge.
    task automatic step(input logic nf, input logic di, input logic vld);
        exp_t e;
        sif.new_frame  = nf;
        sif.ssg_di     = di;
        sif.ssg_di_vld = vld;
        @(posedge ssg_clk);
        cyc++;
        @(negedge ssg_clk);
        sif.new_frame  = 1'b0;
        sif.ssg_di_vld = 1'b0;
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_vec++;
            n_bad++;
            $display("FAIL missing_pulse: got no sig_vld/sig_err, required one at cycle %0d", sb[0].cyc);
            void'(sb.pop_front());
        end
        if (sif.sig_vld || sif.sig_err) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse: got vld=%b err=%b at cycle %0d, required none",
                         sif.sig_vld, sif.sig_err, cyc);
            end else begin
                e = sb.pop_front();
                if ({sif.sig_vld, sif.sig_err, sif.sig_err_code, sif.sig_type, sif.sig_len}
                        !== {!e.is_err, e.is_err, e.code, e.typ, e.len} || e.cyc != cyc) begin
                    n_bad++;
                    $display("FAIL result: got vld=%b err=%b code=%0d type=%h len=%0d cyc=%0d, required vld=%b err=%b code=%0d type=%h len=%0d cyc=%0d",
                             sif.sig_vld, sif.sig_err, sif.sig_err_code, sif.sig_type, sif.sig_len, cyc,
                             !e.is_err, e.is_err, e.code, e.typ, e.len, e.cyc);
                end
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit joint, input int gap_len);
        if (!joint) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            if (i == 31) push_expect(w);
            step(joint && i == 0, w[i], 1'b1);
            if (gap_len > 0 && (i == 5 || i == 20))
                for (int g = 0; g < gap_len; g++) step(1'b0, 1'($urandom), 1'b0);
        end
    endtask

    task automatic check_fields(input string name, input logic [3:0] t, input logic [15:0] l,
                                input logic [1:0] c);
        n_vec++;
        if ({sif.sig_type, sif.sig_len, sif.sig_err_code} !== {t, l, c}) begin
            n_bad++;
            $display("FAIL %s: got type=%h len=%0d code=%0d, required type=%h len=%0d code=%0d",
                     name, sif.sig_type, sif.sig_len, sif.sig_err_code, t, l, c);
        end
    endtask

    task automatic test_reset();
        ssg_rst        = 1'b1;
        sif.new_frame  = 1'b0;
        sif.ssg_di     = 1'b0;
        sif.ssg_di_vld = 1'b0;
        repeat (2) @(negedge ssg_clk);
        n_vec++;
        if ({sif.sig_vld, sif.sig_err, sif.busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_flags: got vld=%b err=%b busy=%b, required 000", sif.sig_vld, sif.sig_err, sif.busy);
        end
        check_fields("reset_fields", 4'h0, 16'd0, 2'd0);
        ssg_rst = 1'b0;
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        n_vec++;
        if (sif.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_ignore: got busy=%b, required 0", sif.busy);
        end
    endtask

    task automatic test_valid();
        send_word(mk_word(8'hB1, 4'h3, 16'd100, 3'd0, 1'b0), 1'b0, 0);
        check_fields("valid_fields", 4'h3, 16'd100, 2'd0);
        step(1'b0, 1'b0, 1'b0);
        n_vec++;
        if (sif.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_after_check: got %b, required 0", sif.busy);
        end
    endtask

    task automatic test_parity();
        send_word(mk_word(8'hB1, 4'h3, 16'd100, 3'd0, 1'b1), 1'b0, 0);
        check_fields("parity_hold", 4'h3, 16'd100, 2'd1);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_priority();
        send_word(mk_word(8'hB0, 4'h2, 16'd0, 3'd0, 1'b0), 1'b0, 0);
        step(1'b0, 1'b0, 1'b0);
        send_word(mk_word(8'hB1, 4'h2, 16'd5000, 3'd0, 1'b0), 1'b0, 0);
        step(1'b0, 1'b0, 1'b0);
        send_word(mk_word(8'hB1, 4'h2, 16'd0, 3'b101, 1'b0), 1'b1, 0);
        check_fields("priority_hold", 4'h3, 16'd100, 2'd2);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        logic [31:0] a;
        a = mk_word(8'hB1, 4'h7, 16'd9, 3'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, a[i], 1'b1);
        n_vec++;
        if (sif.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_collect: got %b, required 1", sif.busy);
        end
        send_word(mk_word(8'hB1, 4'h1, 16'd64, 3'd0, 1'b0), 1'b1, 0);
        check_fields("abort_fields", 4'h1, 16'd64, 2'd2);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_gaps();
        send_word(mk_word(8'hB1, 4'h3, 16'd100, 3'd0, 1'b0), 1'b0, 7);
        check_fields("gap_fields", 4'h3, 16'd100, 2'd2);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [31:0] c;
        int          busy_seen;
        c         = mk_word(8'hB1, 4'h6, 16'd33, 3'd0, 1'b0);
        busy_seen = 0;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, c[i], 1'b1);
        ssg_rst = 1'b1;
        #1;
        n_vec++;
        if (sif.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset_busy: got %b, required 0", sif.busy);
        end
        check_fields("async_reset_fields", 4'h0, 16'd0, 2'd0);
        #1;
        ssg_rst = 1'b0;
        m_type  = '0;
        m_len   = '0;
        m_code  = '0;
        for (int i = 16; i < 32; i++) begin
            step(1'b0, c[i], 1'b1);
            if (sif.busy !== 1'b0) busy_seen++;
        end
        n_vec++;
        if (busy_seen != 0) begin
            n_bad++;
            $display("FAIL post_reset_busy: got busy high on %0d cycles, required 0", busy_seen);
        end
        send_word(mk_word(8'hB1, 4'h5, 16'd4095, 3'd0, 1'b0), 1'b0, 0);
        check_fields("max_len_fields", 4'h5, 16'd4095, 2'd0);
        step(1'b0, 1'b0, 1'b0);
        send_word(mk_word(8'hB1, 4'h5, 16'd4096, 3'd0, 1'b0), 1'b0, 0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        send_word(mk_word(8'hB1, 4'h9, 16'd1, 3'd0, 1'b0), 1'b1, 0);
        send_word(mk_word(8'hB1, 4'h4, 16'd2048, 3'd0, 1'b0), 1'b1, 0);
        send_word(mk_word(8'hB1, 4'hA, 16'd7, 3'd0, 1'b0), 1'b1, 0);
        check_fields("b2b_fields", 4'hA, 16'd7, 2'd3);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_valid();
        test_parity();
        test_priority();
        test_abort();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
